tmds_decoder: RTL and testbench

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_decoder.sv | 162 ++++++++++++++++
 tb/tb_tmds_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: finds the bit alignment of a deserialized 10-bit stream
// by hunting for control tokens, then decodes pixel bytes and control bits.
module tmds_decoder #(
  parameter int unsigned SEARCH_TIMEOUT = 2048,
  parameter int unsigned LOCK_TOKENS    = 8,
  parameter int unsigned LOSS_TIMEOUT   = 4096
) (
  input  logic       pixclk,
  input  logic       rstn,
  input  logic [9:0] tmds_word,
  output logic [7:0] data,
  output logic       de,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic [3:0] bit_offset
);

  localparam int unsigned TMAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX) + 1;
  localparam int unsigned CW   = $clog2(LOCK_TOKENS) + 1;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t          state;
  logic [3:0]      off;
  logic [TW-1:0]   timer;
  logic [CW-1:0]   tok_cnt;
  logic [9:0]      prev_word;

  logic [19:0]     window;
  logic [9:0]      a_word;
  logic            is_tok;
  logic [1:0]      tok_code;

  // Stage-1 copy of the aligned word, paired with the FSM state it produced
  logic [9:0]      a_q;
  logic            tok_q;
  logic [1:0]      code_q;
  logic [7:0]      dec_byte;
  logic [3:0]      off_next;

  assign window   = {tmds_word, prev_word};
  assign a_word   = window[off +: 10];
  assign off_next = (off == 4'd9) ? 4'd0 : off + 4'd1;

  always_comb begin
    is_tok   = 1'b1;
    tok_code = 2'b00;
    case (a_word)
      10'b1101010100: tok_code = 2'b00;
      10'b0010101011: tok_code = 2'b01;
      10'b0101010100: tok_code = 2'b10;
      10'b1010101011: tok_code = 2'b11;
      default:        is_tok   = 1'b0;
    endcase
  end

  always_comb begin
    logic [7:0] v;
    v        = a_q[9] ? ~a_q[7:0] : a_q[7:0];
    dec_byte = '0;
    dec_byte[0] = v[0];
    for (int unsigned i = 1; i < 8; i++) begin
      dec_byte[i] = a_q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    end
  end

  always_ff @(posedge pixclk or negedge rstn) begin
    if (!rstn) begin
      prev_word <= '0;
      state     <= SEARCH;
      off       <= '0;
      timer     <= '0;
      tok_cnt   <= '0;
      a_q       <= '0;
      tok_q     <= 1'b0;
      code_q    <= '0;
    end else begin
      prev_word <= tmds_word;
      a_q       <= a_word;
      tok_q     <= is_tok;
      code_q    <= tok_code;
      case (state)
        SEARCH: begin
          if (is_tok) begin
            timer   <= '0;
            tok_cnt <= CW'(1);
            state   <= (LOCK_TOKENS <= 1) ? LOCKED : VERIFY;
          end else if (timer == TW'(SEARCH_TIMEOUT - 1)) begin
            off   <= off_next;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        VERIFY: begin
          if (is_tok) begin
            tok_cnt <= tok_cnt + CW'(1);
            if (tok_cnt == CW'(LOCK_TOKENS - 1)) begin
              state <= LOCKED;
              timer <= '0;
            end
          end else begin
            state   <= SEARCH;
            off     <= off_next;
            timer   <= '0;
            tok_cnt <= '0;
          end
        end
        LOCKED: begin
          if (is_tok) begin
            timer <= '0;
          end else if (timer == TW'(LOSS_TIMEOUT - 1)) begin
            state   <= SEARCH;
            off     <= off_next;
            timer   <= '0;
            tok_cnt <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state   <= SEARCH;
          off     <= '0;
          timer   <= '0;
          tok_cnt <= '0;
        end
      endcase
    end
  end

  // state/off here already reflect the word held in a_q, so lock gain and loss
  // land on the very word that caused them
  always_ff @(posedge pixclk or negedge rstn) begin
    if (!rstn) begin
      data       <= '0;
      de         <= 1'b0;
      ctrl       <= '0;
      locked     <= 1'b0;
      bit_offset <= '0;
    end else begin
      bit_offset <= off;
      if (state == LOCKED) begin
        locked <= 1'b1;
        if (tok_q) begin
          de   <= 1'b0;
          ctrl <= code_q;
          data <= '0;
        end else begin
          de   <= 1'b1;
          data <= dec_byte;
        end
      end else begin
        locked <= 1'b0;
        de     <= 1'b0;
        ctrl   <= '0;
        data   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: alignment search, lock/loss, byte decode and reset.
module tb_tmds_decoder;

  logic       pixclk = 1'b0;
  logic       rstn   = 1'b0;
  logic [9:0] tmds_word = '0;
  logic [7:0] data;
  logic       de;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] bit_offset;

  tmds_decoder #(
    .SEARCH_TIMEOUT(2048),
    .LOCK_TOKENS   (8),
    .LOSS_TIMEOUT  (4096)
  ) dut (
    .pixclk    (pixclk),
    .rstn      (rstn),
    .tmds_word (tmds_word),
    .data      (data),
    .de        (de),
    .ctrl      (ctrl),
    .locked    (locked),
    .bit_offset(bit_offset)
  );

  always #5 pixclk = ~pixclk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  int unsigned sh   = 10;
  int unsigned sent = 0;
  logic [9:0]  prev_src = '0;

  bit         e_chk [3];
  logic       e_lk  [3];
  logic       e_de  [3];
  logic [7:0] e_dat [3];
  logic [1:0] e_ctl [3];
  logic [3:0] e_off [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serialize src with the current bit slip, drive one word, then compare the
  // outputs belonging to the word sent two calls earlier.
  task automatic send(input logic [9:0] src, input bit chk, input logic lk, input logic dex,
                      input logic [7:0] dat, input logic [1:0] ctl, input logic [3:0] offx);
    logic [19:0] win;
    int unsigned k;
    win       = {src, prev_src} >> sh;
    tmds_word = win[9:0];
    prev_src  = src;
    @(posedge pixclk);
    #1;
    sent++;
    k        = sent % 3;
    e_chk[k] = chk;
    e_lk[k]  = lk;
    e_de[k]  = dex;
    e_dat[k] = dat;
    e_ctl[k] = ctl;
    e_off[k] = offx;
    if (sent >= 3) begin
      k = (sent - 2) % 3;
      if (e_chk[k]) begin
        check("locked", locked, e_lk[k]);
        check("de", de, e_de[k]);
        check("data", data, e_dat[k]);
        check("ctrl", ctrl, e_ctl[k]);
        check("bit_offset", bit_offset, e_off[k]);
      end
    end
  endtask

  task automatic do_reset(input int unsigned shift);
    rstn      = 1'b0;
    tmds_word = '0;
    @(posedge pixclk);
    #1;
    @(negedge pixclk);
    rstn     = 1'b1;
    sent     = 0;
    prev_src = '0;
    sh       = shift;
    for (int i = 0; i < 3; i++) e_chk[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) e_chk[i] = 1'b0;
    tmds_word = 10'h354;
    @(posedge pixclk);
    @(posedge pixclk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_de", de, 0);
    check("rst_data", data, 0);
    check("rst_ctrl", ctrl, 0);
    check("rst_off", bit_offset, 0);
    do_reset(10);

    // Aligned lock, then the three encodings of 0xA5 and control hold
    for (int i = 1; i <= 8; i++) send(10'h354, 1, i == 8, 0, 8'h00, 2'b00, 4'd0);
    send(10'h100, 1, 1, 1, 8'h00, 2'b00, 4'd0);
    send(10'h163, 1, 1, 1, 8'hA5, 2'b00, 4'd0);
    send(10'h39C, 1, 1, 1, 8'hA5, 2'b00, 4'd0);
    send(10'h0C9, 1, 1, 1, 8'hA5, 2'b00, 4'd0);
    send(10'h0AB, 1, 1, 0, 8'h00, 2'b01, 4'd0);
    send(10'h163, 1, 1, 1, 8'hA5, 2'b01, 4'd0);
    send(10'h2AB, 1, 1, 0, 8'h00, 2'b11, 4'd0);
    send(10'h154, 1, 1, 0, 8'h00, 2'b10, 4'd0);
    send(10'h39C, 1, 1, 1, 8'hA5, 2'b10, 4'd0);
    send(10'h0C9, 0, 0, 0, 8'h00, 2'b00, 4'd0);
    send(10'h0C9, 0, 0, 0, 8'h00, 2'b00, 4'd0);
    check("pre_rst_de", de, 1);

    // Asynchronous reset in the middle of a locked data run
    #2 rstn = 1'b0;
    #1;
    check("async_locked", locked, 0);
    check("async_de", de, 0);
    check("async_data", data, 0);
    check("async_ctrl", ctrl, 0);
    check("async_off", bit_offset, 0);
    do_reset(10);

    // Relock needs the full token run again, then loss after 4096 data words
    for (int i = 1; i <= 8; i++) send(10'h354, 1, i == 8, 0, 8'h00, 2'b00, 4'd0);
    for (int i = 1; i <= 4096; i++) begin
      send(10'h163, (i == 1) || (i == 4095) || (i == 4096), i != 4096, i != 4096,
           (i != 4096) ? 8'hA5 : 8'h00, 2'b00, (i == 4096) ? 4'd1 : 4'd0);
    end
    send(10'h163, 0, 0, 0, 8'h00, 2'b00, 4'd0);
    send(10'h163, 0, 0, 0, 8'h00, 2'b00, 4'd0);

    // VERIFY aborted by a data word after five tokens
    do_reset(10);
    for (int i = 1; i <= 5; i++) send(10'h354, i == 5, 0, 0, 8'h00, 2'b00, 4'd0);
    send(10'h163, 1, 0, 0, 8'h00, 2'b00, 4'd1);
    send(10'h163, 0, 0, 0, 8'h00, 2'b00, 4'd0);
    send(10'h163, 0, 0, 0, 8'h00, 2'b00, 4'd0);

    // Stream slipped by 3 bits: walk offsets 0..3 and lock at 3
    do_reset(7);
    for (int i = 1; i <= 6160; i++) begin
      send(10'h354, 0, 0, 0, 8'h00, 2'b00, 4'd0);
      if (i == 2048) check("off_t2048", bit_offset, 0);
      if (i == 2049) check("off_t2049", bit_offset, 1);
      if (i == 4096) check("off_t4096", bit_offset, 1);
      if (i == 4097) check("off_t4097", bit_offset, 2);
      if (i == 6145) check("off_t6145", bit_offset, 3);
      if (i == 6152) check("lock_t6152", locked, 0);
      if (i == 6153) check("lock_t6153", locked, 1);
    end
    send(10'h163, 1, 1, 1, 8'hA5, 2'b00, 4'd3);
    send(10'h39C, 1, 1, 1, 8'hA5, 2'b00, 4'd3);
    send(10'h0C9, 1, 1, 1, 8'hA5, 2'b00, 4'd3);
    send(10'h100, 1, 1, 1, 8'h00, 2'b00, 4'd3);
    send(10'h354, 1, 1, 0, 8'h00, 2'b00, 4'd3);
    send(10'h354, 0, 0, 0, 8'h00, 2'b00, 4'd0);
    send(10'h354, 0, 0, 0, 8'h00, 2'b00, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
